// File: rtl/cop_instr_sequencer_if.sv
// Host load port and coprocessor instruction port of cop_instr_sequencer.
// master: host/coprocessor side; slave: the sequencer itself.
interface cop_instr_sequencer_if #(
  parameter int unsigned INSTR_W = 22
);
  logic               load_valid;
  logic [INSTR_W-1:0] load_instr;
  logic               load_ready;
  logic [INSTR_W-1:0] cop_instr;
  logic               cop_start;
  logic               cop_done;

  modport master (
    output load_valid, load_instr, cop_done,
    input  load_ready, cop_instr, cop_start
  );

  modport slave (
    input  load_valid, load_instr, cop_done,
    output load_ready, cop_instr, cop_start
  );
endinterface

// File: rtl/cop_instr_sequencer.sv
// Program-and-run sequencer: buffers up to DEPTH instructions, then issues them in order,
// one start strobe each, waiting for cop_done. Optional WAIT timeout: SEQ_TIMEOUT_EN.
module cop_instr_sequencer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned INSTR_W = 22,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cop_instr_sequencer_if.slave     bus,
  input  logic                     clear,
  input  logic                     run,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH)-1:0] pc
);
  localparam int unsigned PC_W = $clog2(DEPTH);
  localparam logic [PC_W:0] CNT_FULL = (PC_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic [PC_W:0]      count_q, count_d, count_ld;
  logic [PC_W-1:0]    pc_q, pc_d, pc_nxt;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               start_q, start_d;
  logic               ready_q, ready_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic               wr_en;
  logic               last;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    count_ld = count_q;
    pc_d     = pc_q;
    pc_nxt   = pc_q + 1'b1;
    done_d   = 1'b0;
    start_d  = 1'b0;
    instr_d  = instr_q;
    wr_en    = 1'b0;
    last     = ({1'b0, pc_q} == (count_q - 1'b1));
`ifdef SEQ_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        wr_en = bus.load_valid && ready_q && !clear;
        if (clear)      count_ld = '0;
        else if (wr_en) count_ld = count_q + 1'b1;
        count_d = count_ld;
        // A load accepted alongside run into slot 0 is not in mem yet; forward it.
        if (run && (count_ld != '0)) begin
          state_d = S_ISSUE;
          pc_d    = '0;
          start_d = 1'b1;
          instr_d = (wr_en && (count_q == '0)) ? bus.load_instr : mem_q[0];
`ifdef SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef SEQ_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        if (bus.cop_done) begin
          if (last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
            pc_d    = pc_nxt;
            start_d = 1'b1;
            instr_d = mem_q[pc_nxt];
          end
        end
`ifdef SEQ_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE) && (count_d < CNT_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      ready_q <= 1'b1;
      instr_q <= '0;
`ifdef SEQ_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= start_d;
      ready_q <= ready_d;
      instr_q <= instr_d;
`ifdef SEQ_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  // Program storage is deliberately not reset or erased by clear.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q[PC_W-1:0]] <= bus.load_instr;
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign count          = count_q;
  assign pc             = pc_q;
  assign bus.load_ready = ready_q;
  assign bus.cop_instr  = instr_q;
  assign bus.cop_start  = start_q;
`ifdef SEQ_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_cop_instr_sequencer.sv
// Randomized self-checking bench for cop_instr_sequencer; expected strobes come from a
// program queue model, expected timing from cycle arithmetic.
module tb_cop_instr_sequencer;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned INSTR_W = 22;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned PC_W    = $clog2(DEPTH);

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, run = 1'b0;
  logic busy, done, err;
  logic [PC_W:0]   count;
  logic [PC_W-1:0] pc;

  cop_instr_sequencer_if #(.INSTR_W(INSTR_W)) bus ();

  cop_instr_sequencer #(.DEPTH(DEPTH), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clear(clear), .run(run),
    .busy(busy), .done(done), .err(err), .count(count), .pc(pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;

  logic [INSTR_W-1:0] prog[$];
  logic [INSTR_W-1:0] offers[$];
  logic [INSTR_W-1:0] st_instr[$];
  int                 st_pc[$];
  int                 st_cyc[$];
  int                 done_cnt = 0, done_cyc = 0;

  int          rsp_mode = 0;
  bit          rsp_rand = 0;
  int unsigned rsp_dly = 1, rsp_tmr = 0;

  always @(negedge clk) begin
    if (bus.cop_start) begin
      st_instr.push_back(bus.cop_instr);
      st_pc.push_back(int'(pc));
      st_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    case (rsp_mode)
      2: bus.cop_done = 1'b1;
      1: begin
        bus.cop_done = 1'b0;
        if (bus.cop_start) rsp_tmr = rsp_rand ? $urandom_range(1, 4) : rsp_dly;
        else if (rsp_tmr == 1) begin
          bus.cop_done = 1'b1;
          rsp_tmr = 0;
        end else if (rsp_tmr > 1) rsp_tmr--;
      end
      default: bus.cop_done = 1'b0;
    endcase
  end

  function automatic logic [INSTR_W-1:0] rnd_instr();
    return INSTR_W'($urandom());
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    st_instr.delete(); st_pc.delete(); st_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic drive_loads();
    foreach (offers[i]) begin
      bus.load_valid = 1'b1;
      bus.load_instr = offers[i];
      if (prog.size() < DEPTH) prog.push_back(offers[i]);
      tick();
    end
    bus.load_valid = 1'b0;
    offers.delete();
  endtask

  task automatic pulse_run();
    run = 1'b1; tick(); run = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; prog.delete(); tick(); clear = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    int start = done_cnt;
    while (done_cnt == start && n < bound) begin
      tick(); n++;
    end
    n_checks++;
    if (done_cnt == start) begin
      n_fail++;
      $display("FAIL wait_done: done not seen within %0d cycles", bound);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({busy, done, err, count, pc, bus.cop_start, bus.load_ready} !== {3'b000, {(PC_W+1){1'b0}}, {PC_W{1'b0}}, 2'b01}) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b done=%b err=%b count=%0d pc=%0d start=%b ready=%b",
               busy, done, err, count, pc, bus.cop_start, bus.load_ready);
    end
    n_checks++;
    if (bus.cop_instr !== '0) begin
      n_fail++; $display("FAIL reset_instr: got %h want 0", bus.cop_instr);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.load_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: ready=%b busy=%b want 1/0", bus.load_ready, busy);
    end
  endtask

  task automatic test_program();
    rsp_mode = 1; rsp_rand = 0; rsp_dly = 3;
    pulse_clear();
    offers = '{22'h2FF002, 22'h0FF042, 22'h200092, 22'h2FF402, 22'h0FF442, 22'h200492, 22'h300000};
    drive_loads();
    n_checks++;
    if (count !== prog.size() || bus.load_ready !== 1'b1) begin
      n_fail++; $display("FAIL prog_count: count=%0d ready=%b want %0d/1", count, bus.load_ready, prog.size());
    end
    clear_mon();
    pulse_run();
    wait_done(200);
    tick();
    n_checks++;
    if (st_instr.size() != prog.size()) begin
      n_fail++; $display("FAIL prog_strobes: got %0d want %0d", st_instr.size(), prog.size());
    end else begin
      foreach (prog[i]) begin
        n_checks++;
        if (st_instr[i] !== prog[i] || st_pc[i] != i) begin
          n_fail++; $display("FAIL prog_instr[%0d]: got %h pc %0d want %h pc %0d", i, st_instr[i], st_pc[i], prog[i], i);
        end
        if (i > 0) begin
          n_checks++;
          if (st_cyc[i] - st_cyc[i-1] != 4) begin
            n_fail++; $display("FAIL prog_period[%0d]: got %0d want 4", i, st_cyc[i] - st_cyc[i-1]);
          end
        end
      end
    end
    n_checks++;
    if (done_cnt != 1 || busy !== 1'b0 || pc !== PC_W'(prog.size() - 1)) begin
      n_fail++; $display("FAIL prog_end: done_cnt=%0d busy=%b pc=%0d want 1/0/%0d", done_cnt, busy, pc, prog.size() - 1);
    end
  endtask

  task automatic test_random();
    rsp_mode = 1; rsp_rand = 1;
    for (int it = 0; it < 4; it++) begin
      int n;
      pulse_clear();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) tick();
        offers.push_back(rnd_instr());
        drive_loads();
      end
      clear_mon();
      pulse_run();
      wait_done(400);
      tick();
      n_checks++;
      if (st_instr.size() != prog.size() || done_cnt != 1) begin
        n_fail++; $display("FAIL rand_strobes[%0d]: got %0d done %0d want %0d done 1", it, st_instr.size(), done_cnt, prog.size());
      end else begin
        foreach (prog[i]) begin
          n_checks++;
          if (st_instr[i] !== prog[i]) begin
            n_fail++; $display("FAIL rand_instr[%0d][%0d]: got %h want %h", it, i, st_instr[i], prog[i]);
          end
        end
      end
    end
    rsp_rand = 0;
  endtask

  task automatic test_overflow();
    rsp_mode = 1; rsp_dly = 1;
    pulse_clear();
    for (int i = 0; i < DEPTH + 2; i++) offers.push_back(rnd_instr());
    drive_loads();
    n_checks++;
    if (count !== prog.size() || prog.size() != DEPTH || bus.load_ready !== 1'b0) begin
      n_fail++; $display("FAIL ovf_count: count=%0d ready=%b want %0d/0", count, bus.load_ready, DEPTH);
    end
    clear_mon();
    pulse_run();
    wait_done(100);
    tick();
    n_checks++;
    if (st_instr.size() != DEPTH) begin
      n_fail++; $display("FAIL ovf_strobes: got %0d want %0d", st_instr.size(), DEPTH);
    end else begin
      foreach (prog[i]) begin
        n_checks++;
        if (st_instr[i] !== prog[i]) begin
          n_fail++; $display("FAIL ovf_instr[%0d]: got %h want %h", i, st_instr[i], prog[i]);
        end
      end
    end
  endtask

  task automatic test_ignored();
    rsp_mode = 1; rsp_dly = 6;
    pulse_clear();
    clear_mon();
    pulse_run();
    repeat (5) tick();
    n_checks++;
    if (st_instr.size() != 0 || done_cnt != 0 || busy !== 1'b0 || count !== '0) begin
      n_fail++; $display("FAIL empty_run: strobes=%0d done=%0d busy=%b count=%0d want 0/0/0/0", st_instr.size(), done_cnt, busy, count);
    end
    clear = 1'b1; bus.load_valid = 1'b1; bus.load_instr = rnd_instr();
    tick();
    clear = 1'b0; bus.load_valid = 1'b0;
    n_checks++;
    if (count !== '0) begin
      n_fail++; $display("FAIL clear_wins: count=%0d want 0", count);
    end
    offers.push_back(rnd_instr()); offers.push_back(rnd_instr());
    drive_loads();
    clear_mon();
    pulse_run();
    for (int i = 0; i < 4; i++) begin
      bus.load_valid = 1'b1; bus.load_instr = rnd_instr(); run = 1'b1; clear = i[0];
      tick();
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++; $display("FAIL busy_hold[%0d]: busy=%b want 1", i, busy);
      end
    end
    bus.load_valid = 1'b0; run = 1'b0; clear = 1'b0;
    n_checks++;
    if (count !== prog.size()) begin
      n_fail++; $display("FAIL busy_count: count=%0d want %0d", count, prog.size());
    end
    wait_done(100);
    repeat (4) tick();
    n_checks++;
    if (st_instr.size() != 2 || st_instr[0] !== prog[0] || st_instr[1] !== prog[1] || done_cnt != 1 || count !== 2) begin
      n_fail++; $display("FAIL busy_ignored: strobes=%0d done=%0d count=%0d want 2/1/2", st_instr.size(), done_cnt, count);
    end
  endtask

  task automatic test_back_to_back();
    int n_edge;
    rsp_mode = 2;
    pulse_clear();
    for (int i = 0; i < 3; i++) offers.push_back(rnd_instr());
    drive_loads();
    for (int r = 0; r < 2; r++) begin
      clear_mon();
      n_edge = cyc + 1;
      pulse_run();
      wait_done(50);
      n_checks++;
      if (st_cyc.size() != 3 || done_cnt != 1) begin
        n_fail++; $display("FAIL b2b_count[%0d]: strobes=%0d done=%0d want 3/1", r, st_cyc.size(), done_cnt);
      end else begin
        for (int i = 0; i < 3; i++) begin
          n_checks++;
          if (st_cyc[i] != n_edge + 2*i || st_instr[i] !== prog[i]) begin
            n_fail++; $display("FAIL b2b_strobe[%0d][%0d]: cyc %0d instr %h want cyc %0d instr %h", r, i, st_cyc[i], st_instr[i], n_edge + 2*i, prog[i]);
          end
        end
        n_checks++;
        if (done_cyc != n_edge + 6 || busy !== 1'b0) begin
          n_fail++; $display("FAIL b2b_done[%0d]: done at +%0d busy=%b want +6/0", r, done_cyc - n_edge, busy);
        end
      end
      tick();
    end
    rsp_mode = 0;
    tick();
  endtask

  task automatic test_reset_in_wait();
    int n = 0;
    int seen;
    rsp_mode = 1; rsp_dly = 5;
    pulse_clear();
    for (int i = 0; i < 4; i++) offers.push_back(rnd_instr());
    drive_loads();
    clear_mon();
    pulse_run();
    while (st_pc.size() < 3 && n < 100) begin tick(); n++; end
    tick();
    n_checks++;
    if (pc !== 2 || busy !== 1'b1 || bus.cop_start !== 1'b0) begin
      n_fail++; $display("FAIL rstw_pre: pc=%0d busy=%b start=%b want 2/1/0", pc, busy, bus.cop_start);
    end
    rst_n = 1'b0;
    tick();
    prog.delete();
    n_checks++;
    if ({busy, done, err, count, pc, bus.cop_start, bus.load_ready} !== {3'b000, {(PC_W+1){1'b0}}, {PC_W{1'b0}}, 2'b01} || bus.cop_instr !== '0) begin
      n_fail++; $display("FAIL rstw_vals: busy=%b done=%b err=%b count=%0d pc=%0d start=%b ready=%b instr=%h",
                         busy, done, err, count, pc, bus.cop_start, bus.load_ready, bus.cop_instr);
    end
    rst_n = 1'b1;
    seen = st_instr.size();
    repeat (12) tick();
    n_checks++;
    if (st_instr.size() != seen || done_cnt != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstw_after: strobes %0d->%0d done=%0d busy=%b want no change/0/0", seen, st_instr.size(), done_cnt, busy);
    end
  endtask

  task automatic test_timeout();
    rsp_mode = 0;
    pulse_clear();
    offers.push_back(rnd_instr()); offers.push_back(rnd_instr());
    drive_loads();
    clear_mon();
    pulse_run();
`ifdef SEQ_TIMEOUT_EN
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      n_checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL tmo_wait[%0d]: err=%b busy=%b want 0/1", k, err, busy);
      end
    end
    tick();
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || pc !== '0 || done_cnt != 0 || st_instr.size() != 1) begin
      n_fail++; $display("FAIL tmo_fire: err=%b busy=%b pc=%0d done=%0d strobes=%0d want 1/0/0/0/1",
                         err, busy, pc, done_cnt, st_instr.size());
    end
    repeat (3) tick();
    rsp_mode = 1; rsp_dly = 1;
    clear_mon();
    pulse_run();
    n_checks++;
    if (err !== 1'b0 || bus.cop_start !== 1'b1) begin
      n_fail++; $display("FAIL tmo_clear: err=%b start=%b want 0/1", err, bus.cop_start);
    end
    wait_done(50);
    n_checks++;
    if (st_instr.size() != 2 || st_instr[0] !== prog[0] || st_instr[1] !== prog[1]) begin
      n_fail++; $display("FAIL tmo_rerun: strobes=%0d want 2 matching", st_instr.size());
    end
`else
    for (int k = 1; k <= 40; k++) begin
      tick();
      n_checks++;
      if (err !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: err=%b busy=%b done=%b want 0/1/0", k, err, busy, done);
      end
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    prog.delete();
    tick();
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b0 || st_instr.size() != 1) begin
      n_fail++; $display("FAIL stall_reset: busy=%b err=%b strobes=%0d want 0/0/1", busy, err, st_instr.size());
    end
`endif
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_instr = '0;
    bus.cop_done   = 1'b0;
    test_reset();
    test_program();
    test_random();
    test_overflow();
    test_ignored();
    test_back_to_back();
    test_reset_in_wait();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cop_instr_sequencer.md
# cop_instr_sequencer

Program-and-run controller for the matrix coprocessor's 22-bit instruction port. A host loads up to DEPTH instructions, pulses `run`, and the block issues them to the coprocessor in load order, one start pulse per instruction, waiting for the coprocessor's completion before advancing. It replaces one-button-per-instruction stepping as the sole driver of the coprocessor's instruction and start inputs.

## Interface
- `DEPTH`, 8: program slots, power of two, 2..64.
- `INSTR_W`, 22: instruction width; `[21:20]` opcode, `[19:12]` data, `[11:10]` matrix select, `[9:7]` row, `[6:4]` col, `[3:0]` size.
- `TIMEOUT`, 1023: cycles allowed in WAIT; used only with `SEQ_TIMEOUT_EN`.

- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `load_valid` in 1: host offers `load_instr` this cycle.
- `load_instr` in INSTR_W: instruction to append.
- `load_ready` out 1: slot free and state IDLE.
- `clear` in 1: empty the program; honoured only in IDLE.
- `run` in 1: start executing the loaded program; honoured only in IDLE.
- `busy` out 1: high in ISSUE and WAIT.
- `done` out 1: one-cycle pulse when the last instruction completes.
- `err` out 1: sticky timeout flag; cleared by `run` or reset.
- `count` out log2(DEPTH)+1: instructions loaded.
- `pc` out log2(DEPTH): index of the instruction being or last issued.
- `cop_instr` out INSTR_W: instruction presented to the coprocessor.
- `cop_start` out 1: one-cycle start strobe.
- `cop_done` in 1: coprocessor completion, level or pulse.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: `load_valid && load_ready` writes `mem[count]` and increments `count`. `load_ready = (count < DEPTH)` in IDLE, else 0. Offers when not ready are dropped.
- `clear` in IDLE sets `count` to 0. Memory contents are not erased.
- Same-cycle `clear` and load: clear wins and the load is dropped.
- `run` in IDLE with `count > 0` sets `pc` to 0, clears `err` and enters ISSUE. `run` with `count == 0` is ignored: no strobe, no `done`.
- If `run` and a load arrive in the same cycle, the load is accepted first and the run covers the new `count`.
- ISSUE: `cop_start = 1` for exactly this cycle and `cop_instr = mem[pc]`. Next state is WAIT.
- WAIT: `cop_instr` holds `mem[pc]`.
  - `cop_done = 1` with `pc == count-1`: go to IDLE and pulse `done`.
  - `cop_done = 1` otherwise: increment `pc` and go to ISSUE.
- `cop_done` is sampled only in WAIT. A `done` asserted during ISSUE is ignored.
- `run`, `clear` and `load_valid` are ignored while `busy`.
- Opcode field is passed through unmodified. The sequencer does not decode instructions.
- Reset at any point: state IDLE, `count = 0`, `pc = 0`, `busy = 0`, `done = 0`, `err = 0`, `cop_start = 0`, `cop_instr = 0`, `load_ready = 1`. An in-flight coprocessor operation is abandoned.

## Timing
- All outputs are registered.
- `run` sampled at edge N: `cop_start` is high in cycle N+1.
- `cop_done` sampled at edge M in WAIT:
  - next `cop_start` is high in cycle M+1;
  - or, for the last instruction, `done` is high in cycle M+1 and `busy` is low.
- Minimum per-instruction period is 2 cycles (ISSUE plus a WAIT that sees `cop_done` immediately).
- A program of K instructions with an immediate `cop_done` each time runs `run` to `done` in 2K cycles.
- Back-to-back runs: `run` is accepted in the cycle after `done`. The program is re-executed unchanged.
- `count` updates in the cycle after an accepted load. `load_ready` drops in the same update that makes `count == DEPTH`.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - a WAIT cycle counter resets on entry to WAIT;
  - reaching TIMEOUT cycles without `cop_done` sets `err`, forces IDLE, and produces no `done` pulse;
  - `pc` holds the index of the stalled instruction.
- Undefined: no counter is built, WAIT lasts indefinitely, and `err` is tied to 0.

## Test plan
- Load 7 instructions (`0x2FF002`, `0x0FF042`, `0x200092`, `0x2FF402`, `0x0FF442`, `0x200492`, `0x300000`), pulse `run`, model `cop_done` 3 cycles after each start -> 7 strobes with matching `cop_instr` in load order, one `done`, `busy` low afterwards.
- Load DEPTH+2 instructions while IDLE -> `count == DEPTH`, `load_ready == 0`, the last 2 dropped, and a run issues exactly DEPTH strobes.
- `run` with `count == 0`, then `clear` plus a load in the same cycle, then loads and `run` while busy -> no strobe; `count` stays 0; busy-time loads and `run` are ignored and `count` is unchanged.
- Hold `cop_done` high permanently and run 3 instructions -> strobes 2 cycles apart, `done` exactly 6 cycles after `run` is sampled.
- Deassert `rst_n` for one cycle while in WAIT at `pc == 2` -> all outputs at reset values next cycle and no further `cop_start`.
- With `SEQ_TIMEOUT_EN` and `TIMEOUT = 16`, never assert `cop_done` -> `err` goes high exactly 16 WAIT cycles after the first strobe, state returns to IDLE with no `done`, and the next `run` clears `err`.
